// File: rtl/simple_proc_alu_pkg.sv
// Shared constants, opcode encodings and shifter mode type for the simple processor ALU.
package simple_proc_alu_pkg;

   localparam int DATA_W = 16;
   localparam int OPC_W  = 4;
   localparam int IMM_W  = 7;

   localparam logic [OPC_W-1:0] OP_ADD  = 4'd0;
   localparam logic [OPC_W-1:0] OP_SUB  = 4'd1;
   localparam logic [OPC_W-1:0] OP_MUL  = 4'd2;
   localparam logic [OPC_W-1:0] OP_ORR  = 4'd3;
   localparam logic [OPC_W-1:0] OP_AND  = 4'd4;
   localparam logic [OPC_W-1:0] OP_XOR  = 4'd5;
   localparam logic [OPC_W-1:0] OP_MOVI = 4'd6;
   localparam logic [OPC_W-1:0] OP_MOV  = 4'd7;
   localparam logic [OPC_W-1:0] OP_LSR  = 4'd8;
   localparam logic [OPC_W-1:0] OP_LSL  = 4'd9;
   localparam logic [OPC_W-1:0] OP_ROR  = 4'd10;
   localparam logic [OPC_W-1:0] OP_CMP  = 4'd11;
   localparam logic [OPC_W-1:0] OP_ADR  = 4'd12;

   typedef enum logic [1:0] {
      SH_LSR = 2'd0,
      SH_LSL = 2'd1,
      SH_ROR = 2'd2
   } shift_mode_e;

   // Only arithmetic ops and CMP touch the condition flags; everything else holds them.
   function automatic logic sets_flags(input logic [OPC_W-1:0] opc);
      return (opc == OP_ADD) || (opc == OP_SUB) || (opc == OP_MUL) || (opc == OP_CMP);
   endfunction

endpackage

// File: rtl/simple_proc_alu_if.sv
// Operand/opcode inputs and result/flag outputs of the ALU, bundled for the datapath.
interface simple_proc_alu_if;
   import simple_proc_alu_pkg::*;

   logic [OPC_W-1:0]  opcode;
   logic [IMM_W-1:0]  immediate_offset;
   logic [DATA_W-1:0] operand_1;
   logic [DATA_W-1:0] operand_2;
   logic [DATA_W-1:0] result;
   logic              overflow;
   logic              carry;
   logic              negative;
   logic              zero;

   modport master (
      output opcode, immediate_offset, operand_1, operand_2,
      input  result, overflow, carry, negative, zero
   );

   modport slave (
      input  opcode, immediate_offset, operand_1, operand_2,
      output result, overflow, carry, negative, zero
   );
endinterface

// File: rtl/simple_proc_alu_shifter.sv
// Combinational barrel shifter for LSR, LSL and ROR by a 4-bit amount.
module simple_proc_alu_shifter
   import simple_proc_alu_pkg::*;
(
   input  logic [DATA_W-1:0] op1,
   input  logic [3:0]        amt,
   input  shift_mode_e       mode,
   output logic [DATA_W-1:0] shifted
);

   always_comb begin
      shifted = op1 >> amt;
      case (mode)
         SH_LSR:  shifted = op1 >> amt;
         SH_LSL:  shifted = op1 << amt;
         // A left shift by 16 vacates the word, so amt=0 yields op1 unchanged.
         SH_ROR:  shifted = (op1 >> amt) | (op1 << (5'd16 - {1'b0, amt}));
         default: shifted = op1 >> amt;
      endcase
   end

endmodule

// File: rtl/simple_proc_alu.sv
// Registered 16-bit ALU with sticky N/Z/C/V flags.
// Define SIMPLE_PROC_ALU_MUL_OVF_EN to have MUL write V from the full signed product.
module simple_proc_alu
   import simple_proc_alu_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   simple_proc_alu_if.slave alu
);

   logic [DATA_W-1:0] result_q, result_d;
   logic              n_q, n_d;
   logic              z_q, z_d;
   logic              c_q, c_d;
   logic              v_q, v_d;

   logic [DATA_W:0]   sum_ext;
   logic [DATA_W:0]   diff_ext;
   logic [DATA_W-1:0] mul_lo;
   logic [DATA_W-1:0] shift_out;
   logic [DATA_W-1:0] s;
   shift_mode_e       shift_mode;

   assign sum_ext  = {1'b0, alu.operand_1} + {1'b0, alu.operand_2};
   assign diff_ext = {1'b0, alu.operand_1} - {1'b0, alu.operand_2};

`ifdef SIMPLE_PROC_ALU_MUL_OVF_EN
   logic signed [2*DATA_W-1:0] prod_full;
   logic                       mul_ovf;

   assign prod_full = $signed({{DATA_W{alu.operand_1[DATA_W-1]}}, alu.operand_1}) *
                      $signed({{DATA_W{alu.operand_2[DATA_W-1]}}, alu.operand_2});
   assign mul_lo    = prod_full[DATA_W-1:0];
   // Product fits in 16 signed bits only when bits 31..15 are all equal.
   assign mul_ovf   = !((&prod_full[2*DATA_W-1:DATA_W-1]) || !(|prod_full[2*DATA_W-1:DATA_W-1]));
`else
   assign mul_lo    = alu.operand_1 * alu.operand_2;
`endif

   always_comb begin
      shift_mode = SH_LSR;
      if (alu.opcode == OP_LSL)      shift_mode = SH_LSL;
      else if (alu.opcode == OP_ROR) shift_mode = SH_ROR;
   end

   simple_proc_alu_shifter u_shifter (
      .op1     (alu.operand_1),
      .amt     (alu.immediate_offset[3:0]),
      .mode    (shift_mode),
      .shifted (shift_out)
   );

   always_comb begin
      s   = '0;
      n_d = n_q;
      z_d = z_q;
      c_d = c_q;
      v_d = v_q;

      case (alu.opcode)
         OP_ADD: begin
            s   = sum_ext[DATA_W-1:0];
            c_d = sum_ext[DATA_W];
            v_d = (alu.operand_1[DATA_W-1] == alu.operand_2[DATA_W-1]) &&
                  (s[DATA_W-1] != alu.operand_1[DATA_W-1]);
         end
         OP_SUB, OP_CMP: begin
            s   = diff_ext[DATA_W-1:0];
            c_d = ~diff_ext[DATA_W];
            v_d = (alu.operand_1[DATA_W-1] != alu.operand_2[DATA_W-1]) &&
                  (s[DATA_W-1] != alu.operand_1[DATA_W-1]);
         end
         OP_MUL: begin
            s = mul_lo;
`ifdef SIMPLE_PROC_ALU_MUL_OVF_EN
            v_d = mul_ovf;
`endif
         end
         OP_ORR:                 s = alu.operand_1 | alu.operand_2;
         OP_AND:                 s = alu.operand_1 & alu.operand_2;
         OP_XOR:                 s = alu.operand_1 ^ alu.operand_2;
         OP_MOVI, OP_ADR:        s = {{(DATA_W-IMM_W){1'b0}}, alu.immediate_offset};
         OP_MOV:                 s = alu.operand_1;
         OP_LSR, OP_LSL, OP_ROR: s = shift_out;
         default:                s = '0;
      endcase

      if (sets_flags(alu.opcode)) begin
         n_d = s[DATA_W-1];
         z_d = (s == '0);
      end

      result_d = (alu.opcode == OP_CMP) ? '0 : s;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result_q <= '0;
         n_q      <= 1'b0;
         z_q      <= 1'b0;
         c_q      <= 1'b0;
         v_q      <= 1'b0;
      end else begin
         result_q <= result_d;
         n_q      <= n_d;
         z_q      <= z_d;
         c_q      <= c_d;
         v_q      <= v_d;
      end
   end

   assign alu.result   = result_q;
   assign alu.negative = n_q;
   assign alu.zero     = z_q;
   assign alu.carry    = c_q;
   assign alu.overflow = v_q;

endmodule

// File: tb/tb_simple_proc_alu.sv
// Directed self-checking bench for simple_proc_alu; flags compared as {N,Z,C,V}.
module tb_simple_proc_alu;
   import simple_proc_alu_pkg::*;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   simple_proc_alu_if alu_bus ();

   simple_proc_alu dut (
      .clk   (clk),
      .reset (reset),
      .alu   (alu_bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic run_op(input logic [3:0] opc, input logic [6:0] imm,
                         input logic [15:0] a, input logic [15:0] b);
      @(negedge clk);
      alu_bus.opcode           = opc;
      alu_bus.immediate_offset = imm;
      alu_bus.operand_1        = a;
      alu_bus.operand_2        = b;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [3:0] flags;
      run_op(OP_ADD, 7'd0, 16'hFFFF, 16'h0001);
      run_op(OP_SUB, 7'd0, 16'h0005, 16'h0007);
      reset = 1'b1;
      run_op(OP_ADD, 7'd0, 16'h7FFF, 16'h0001);
      reset = 1'b0;
      flags = {alu_bus.negative, alu_bus.zero, alu_bus.carry, alu_bus.overflow};
      checks++;
      if (alu_bus.result !== 16'h0000) begin
         errors++;
         $display("[TB] FAIL reset_result got %h want %h", alu_bus.result, 16'h0000);
      end
      checks++;
      if (flags !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL reset_flags got %b want %b", flags, 4'b0000);
      end
      run_op(OP_ORR, 7'd0, 16'h00F0, 16'h000F);
      flags = {alu_bus.negative, alu_bus.zero, alu_bus.carry, alu_bus.overflow};
      checks++;
      if (alu_bus.result !== 16'h00FF) begin
         errors++;
         $display("[TB] FAIL orr_result got %h want %h", alu_bus.result, 16'h00FF);
      end
      checks++;
      if (flags !== 4'b0000) begin
         errors++;
         $display("[TB] FAIL orr_flags_held got %b want %b", flags, 4'b0000);
      end
   endtask

   // Each row: opcode, a, b, expected result, expected {N,Z,C,V}
   task automatic test_arith();
      logic [3:0]  opc [5] = '{OP_ADD, OP_ADD, OP_SUB, OP_CMP, OP_CMP};
      logic [15:0] a   [5] = '{16'hFFFF, 16'h7FFF, 16'h0005, 16'h0007, 16'h8000};
      logic [15:0] b   [5] = '{16'h0001, 16'h0001, 16'h0007, 16'h0007, 16'h0001};
      logic [15:0] er  [5] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h0000, 16'h0000};
      logic [3:0]  ef  [5] = '{4'b0110, 4'b1001, 4'b1000, 4'b0110, 4'b0011};
      logic [3:0]  flags;
      for (int i = 0; i < 5; i++) begin
         run_op(opc[i], 7'd0, a[i], b[i]);
         flags = {alu_bus.negative, alu_bus.zero, alu_bus.carry, alu_bus.overflow};
         checks++;
         if (alu_bus.result !== er[i]) begin
            errors++;
            $display("[TB] FAIL arith%0d_result got %h want %h", i, alu_bus.result, er[i]);
         end
         checks++;
         if (flags !== ef[i]) begin
            errors++;
            $display("[TB] FAIL arith%0d_flags got %b want %b", i, flags, ef[i]);
         end
      end
   endtask

   task automatic test_mul();
      logic [3:0] flags;
      logic [3:0] want;
`ifdef SIMPLE_PROC_ALU_MUL_OVF_EN
      want = 4'b1010;
`else
      want = 4'b1011;
`endif
      run_op(OP_MUL, 7'd0, 16'hFFFE, 16'h0003);
      flags = {alu_bus.negative, alu_bus.zero, alu_bus.carry, alu_bus.overflow};
      checks++;
      if (alu_bus.result !== 16'hFFFA) begin
         errors++;
         $display("[TB] FAIL mul_result got %h want %h", alu_bus.result, 16'hFFFA);
      end
      checks++;
      if (flags !== want) begin
         errors++;
         $display("[TB] FAIL mul_flags got %b want %b", flags, want);
      end
   endtask

   // Runs after test_mul, so every row expects the flags it left behind.
   task automatic test_shift_misc();
      logic [3:0]  opc [10] = '{OP_LSR, OP_LSL, OP_ROR, OP_ROR, OP_MOVI, OP_ADR, OP_MOV,
                                4'd13, 4'd14, 4'd15};
      logic [6:0]  imm [10] = '{7'd1, 7'd4, 7'd1, 7'd0, 7'h7F, 7'd5, 7'd0, 7'd3, 7'd3, 7'd3};
      logic [15:0] a   [10] = '{16'h8001, 16'h8001, 16'h8001, 16'h8001, 16'hAAAA, 16'hAAAA,
                                16'h1234, 16'hFFFF, 16'h1234, 16'h8001};
      logic [15:0] er  [10] = '{16'h4000, 16'h0010, 16'hC000, 16'h8001, 16'h007F, 16'h0005,
                                16'h1234, 16'h0000, 16'h0000, 16'h0000};
      logic [3:0]  want;
      logic [3:0]  flags;
`ifdef SIMPLE_PROC_ALU_MUL_OVF_EN
      want = 4'b1010;
`else
      want = 4'b1011;
`endif
      for (int i = 0; i < 10; i++) begin
         run_op(opc[i], imm[i], a[i], 16'h5555);
         flags = {alu_bus.negative, alu_bus.zero, alu_bus.carry, alu_bus.overflow};
         checks++;
         if (alu_bus.result !== er[i]) begin
            errors++;
            $display("[TB] FAIL op%0d_result got %h want %h", opc[i], alu_bus.result, er[i]);
         end
         checks++;
         if (flags !== want) begin
            errors++;
            $display("[TB] FAIL op%0d_flags_held got %b want %b", opc[i], flags, want);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] flags;
      run_op(OP_XOR, 7'd0, 16'hF0F0, 16'hFF00);
      checks++;
      if (alu_bus.result !== 16'h0FF0) begin
         errors++;
         $display("[TB] FAIL xor_result got %h want %h", alu_bus.result, 16'h0FF0);
      end
      run_op(OP_AND, 7'd0, 16'hF0F0, 16'hFF00);
      checks++;
      if (alu_bus.result !== 16'hF000) begin
         errors++;
         $display("[TB] FAIL and_result got %h want %h", alu_bus.result, 16'hF000);
      end
      run_op(OP_SUB, 7'd0, 16'h0009, 16'h0002);
      flags = {alu_bus.negative, alu_bus.zero, alu_bus.carry, alu_bus.overflow};
      checks++;
      if ((alu_bus.result !== 16'h0007) || (flags !== 4'b0010)) begin
         errors++;
         $display("[TB] FAIL sub_b2b got %h/%b want %h/%b", alu_bus.result, flags, 16'h0007, 4'b0010);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      alu_bus.opcode           = OP_ADD;
      alu_bus.immediate_offset = '0;
      alu_bus.operand_1        = '0;
      alu_bus.operand_2        = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      test_reset();
      test_arith();
      test_mul();
      test_shift_misc();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
